sme_host_tx: RTL and testbench
==============================

// Module: sme_host_tx
// PURPOSE
//  Host-side driver for the string-match engine: buffers one string (<=STR_MAX chars) and one pattern
//  (<=PAT_MAX chars) written by the host, serializes them onto chardata/isstring/ispattern, waits for
//  the engine's valid, and returns match/match_index as a one-shot result. Sits between host/test
//  sequencer and the match engine; it is the transmit end of the engine's input protocol.
// PARAMETERS
//  STR_MAX  32    string buffer depth (chars); slen counter 6 bits
//  PAT_MAX  8     pattern buffer depth (chars); plen counter 4 bits
//  TIMEOUT  1023  max WAIT cycles for sme_valid before the job is abandoned (>=2)
// PORTS
//  clk             in   1  clock, all logic on rising edge
//  reset           in   1  synchronous, active-high reset
//  wr_en           in   1  append wr_data to buffer selected by wr_sel (IDLE only)
//  wr_sel          in   1  0 = string buffer, 1 = pattern buffer
//  wr_data         in   8  ASCII char
//  wr_ovf          out  1  sticky: a write exceeded buffer depth; cleared by accepted start
//  start           in   1  launch job (IDLE only)
//  keep_string     in   1  sampled with start: 1 = send pattern only, engine reuses last string
//  busy            out  1  job in progress (SEND_S, SEND_P, WAIT, REPORT)
//  done            out  1  one-cycle pulse, results valid
//  err             out  1  one-cycle pulse, start rejected
//  res_match       out  1  engine match result (0 on timeout)
//  res_index       out  5  engine match_index (0 on timeout)
//  res_timeout     out  1  job ended by timeout
//  chardata        out  8  char to engine
//  isstring        out  1  chardata is a string char
//  ispattern       out  1  chardata is a pattern char
//  sme_valid       in   1  engine result strobe
//  sme_match       in   1  engine match
//  sme_match_index in   5  engine match index
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, slen=plen=0, str_fresh=0, timeout counter 0. Buffer contents undefined.
//  - All outputs registered. States: IDLE, SEND_S, SEND_P, WAIT, REPORT.
//  - Writes (IDLE, start=0): string write stores at slen, slen++; pattern write at plen, plen++.
//    Write when count==depth: dropped, wr_ovf<=1. First string write after a REPORT (str_fresh=1)
//    restarts the string: stores at 0, slen<=1, str_fresh<=0. wr_en outside IDLE ignored.
//  - start in IDLE: rejected (err pulse next cycle, stay IDLE, no engine activity) if plen==0, or
//    keep_string=0 and slen==0, or keep_string=1 and no string ever sent since reset. Otherwise
//    accepted; wr_en same cycle dropped; wr_ovf<=0; go SEND_S (keep_string=0) or SEND_P.
//  - start while busy: ignored, no err.
//  - Timing, start accepted cycle T, L=slen, P=plen: isstring=1 cycles T+1..T+L with string[0..L-1];
//    ispattern=1 cycles T+L+1..T+L+P with pattern[0..P-1] (keep_string: T+1..T+P).
//    Pattern MUST follow last string char with no gap (engine leaves string rx when isstring drops).
//    isstring and ispattern never both 1; chardata=0 when both 0.
//  - WAIT: counter clears on entry, increments each cycle without sme_valid. sme_valid=1 -> capture
//    sme_match/sme_match_index, go REPORT. Counter==TIMEOUT-1 with no valid -> REPORT, res_match=0,
//    res_index=0, res_timeout=1. sme_valid outside WAIT ignored.
//  - REPORT (1 cycle): done=1; plen<=0; str_fresh<=1; next IDLE. res_* hold until next done or reset.
//  - res_timeout cleared on every non-timeout done.
//  - reset mid-job: at next edge isstring/ispattern/busy drop to 0, no done pulse.
// TESTING
//  1. write string "ab ca" (61 62 20 63 61), pattern "ca", start at T -> isstring T+1..T+5 with those
//     bytes, ispattern T+6..T+7 (63 61); model valid match=1 idx=3 at T+10 -> done T+11, res_match=1, res_index=3.
//  2. after test 1, pattern "^a", start keep_string=1 at T -> no isstring, ispattern T+1..T+2 (5E 61).
//  3. TIMEOUT=16, no sme_valid -> WAIT lasts 16 cycles, done with res_timeout=1, res_match=0, res_index=0.
//  4. 9 pattern writes -> wr_ovf=1, plen=8, only first 8 bytes sent; wr_ovf clears on start.
//  5. start with plen=0 -> err pulse 1 cycle later, busy=0, isstring=ispattern=0 throughout.
//  6. reset at 3rd isstring cycle -> next cycle isstring=0, busy=0, done never pulses; later start -> err (no string).

Source files
------------

// File: rtl/sme_host_tx_if.sv
// Engine-side link of the string-match host driver.
// The host (master) streams characters out and receives the engine's result strobe.
interface sme_host_tx_if;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_match_index;

  modport master (output chardata, isstring, ispattern,
                  input  sme_valid, sme_match, sme_match_index);
  modport slave  (input  chardata, isstring, ispattern,
                  output sme_valid, sme_match, sme_match_index);
endinterface

// File: rtl/sme_host_tx.sv
// Host-side transmitter for the string-match engine.
// Buffers one string and one pattern, streams them to the engine back to back,
// waits for the engine result (bounded by TIMEOUT), and reports it once.
module sme_host_tx #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic          wr_sel_i,
  input  logic [7:0]    wr_data_i,
  output logic          wr_ovf_o,
  input  logic          start_i,
  input  logic          keep_string_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          res_match_o,
  output logic [4:0]    res_index_o,
  output logic          res_timeout_o,
  sme_host_tx_if.master eng
);
  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int IW  = (SLW > PLW) ? SLW : PLW;
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_SEND_S, S_SEND_P, S_WAIT, S_REPORT} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [SLW-1:0] slen_q, slen_d;
  logic [PLW-1:0] plen_q, plen_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           str_fresh_q, str_fresh_d;
  logic           str_sent_q, str_sent_d;
  logic           wr_ovf_q, wr_ovf_d;
  logic [7:0]     chardata_q, chardata_d;
  logic           isstring_q, isstring_d;
  logic           ispattern_q, ispattern_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           res_match_q, res_match_d;
  logic [4:0]     res_index_q, res_index_d;
  logic           res_timeout_q, res_timeout_d;

  logic [7:0]     str_mem [STR_MAX];
  logic [7:0]     pat_mem [PAT_MAX];
  logic           str_we, pat_we;
  logic [SAW-1:0] str_wa;
  logic [PAW-1:0] pat_wa;
  logic           start_ok;

  // A job needs a pattern plus either a buffered string or one already held by the engine.
  assign start_ok = (plen_q != '0) && (keep_string_i ? str_sent_q : (slen_q != '0));

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slen_d        = slen_q;
    plen_d        = plen_q;
    tmo_d         = tmo_q;
    str_fresh_d   = str_fresh_q;
    str_sent_d    = str_sent_q;
    wr_ovf_d      = wr_ovf_q;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    chardata_d    = '0;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    str_we        = 1'b0;
    str_wa        = '0;
    pat_we        = 1'b0;
    pat_wa        = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (!start_ok) begin
            err_d = 1'b1;
          end else begin
            wr_ovf_d = 1'b0;
            idx_d    = IW'(1);
            if (!keep_string_i) begin
              state_d    = S_SEND_S;
              isstring_d = 1'b1;
              chardata_d = str_mem[0];
              str_sent_d = 1'b1;
            end else begin
              state_d     = S_SEND_P;
              ispattern_d = 1'b1;
              chardata_d  = pat_mem[0];
            end
          end
        end else if (wr_en_i) begin
          if (!wr_sel_i) begin
            // After a report the next string write starts a new string.
            if (str_fresh_q) begin
              str_we      = 1'b1;
              str_wa      = '0;
              slen_d      = SLW'(1);
              str_fresh_d = 1'b0;
            end else if (slen_q == SLW'(STR_MAX)) begin
              wr_ovf_d = 1'b1;
            end else begin
              str_we = 1'b1;
              str_wa = slen_q[SAW-1:0];
              slen_d = slen_q + SLW'(1);
            end
          end else begin
            if (plen_q == PLW'(PAT_MAX)) begin
              wr_ovf_d = 1'b1;
            end else begin
              pat_we = 1'b1;
              pat_wa = plen_q[PAW-1:0];
              plen_d = plen_q + PLW'(1);
            end
          end
        end
      end
      S_SEND_S: begin
        // The pattern's first char must follow the last string char with no gap.
        if (idx_q == IW'(slen_q)) begin
          state_d     = S_SEND_P;
          idx_d       = IW'(1);
          ispattern_d = 1'b1;
          chardata_d  = pat_mem[0];
        end else begin
          isstring_d = 1'b1;
          chardata_d = str_mem[idx_q[SAW-1:0]];
          idx_d      = idx_q + IW'(1);
        end
      end
      S_SEND_P: begin
        if (idx_q == IW'(plen_q)) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end else begin
          ispattern_d = 1'b1;
          chardata_d  = pat_mem[idx_q[PAW-1:0]];
          idx_d       = idx_q + IW'(1);
        end
      end
      S_WAIT: begin
        if (eng.sme_valid) begin
          state_d       = S_REPORT;
          done_d        = 1'b1;
          res_match_d   = eng.sme_match;
          res_index_d   = eng.sme_match_index;
          res_timeout_d = 1'b0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d       = S_REPORT;
          done_d        = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_REPORT: begin
        state_d     = S_IDLE;
        plen_d      = '0;
        str_fresh_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      slen_q        <= '0;
      plen_q        <= '0;
      tmo_q         <= '0;
      str_fresh_q   <= 1'b0;
      str_sent_q    <= 1'b0;
      wr_ovf_q      <= 1'b0;
      chardata_q    <= '0;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slen_q        <= slen_d;
      plen_q        <= plen_d;
      tmo_q         <= tmo_d;
      str_fresh_q   <= str_fresh_d;
      str_sent_q    <= str_sent_d;
      wr_ovf_q      <= wr_ovf_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // Character buffers; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_wa] <= wr_data_i;
    if (pat_we) pat_mem[pat_wa] <= wr_data_i;
  end

  assign eng.chardata  = chardata_q;
  assign eng.isstring  = isstring_q;
  assign eng.ispattern = ispattern_q;
  assign wr_ovf_o      = wr_ovf_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign res_match_o   = res_match_q;
  assign res_index_o   = res_index_q;
  assign res_timeout_o = res_timeout_q;
endmodule

// File: tb/tb_sme_host_tx.sv
// Bench for sme_host_tx: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against a cycle-scheduled job model.
module tb_sme_host_tx;
  localparam int SMAX = 32;
  localparam int PMAX = 8;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, keep_string = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ovf, busy, done, err, res_match, res_timeout;
  logic [4:0] res_index;

  sme_host_tx_if eng ();

  sme_host_tx #(.STR_MAX(SMAX), .PAT_MAX(PMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(rst),
    .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_data_i(wr_data), .wr_ovf_o(wr_ovf),
    .start_i(start), .keep_string_i(keep_string),
    .busy_o(busy), .done_o(done), .err_o(err),
    .res_match_o(res_match), .res_index_o(res_index), .res_timeout_o(res_timeout),
    .eng(eng)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // ---------------- job model ----------------
  int         cyc = 0;
  logic [7:0] m_str[$];
  logic [7:0] m_pat[$];
  logic [7:0] m_js[$];
  logic [7:0] m_jp[$];
  logic       m_fresh = 1'b0, m_sent = 1'b0, m_ovf = 1'b0, m_job = 1'b0;
  logic       m_rm = 1'b0, m_rt = 1'b0;
  logic [4:0] m_ri = '0;
  int         m_T = 0, m_Ls = 0, m_P = 0, m_ws = 0, m_done = -1, m_err = -1;
  int         ce;

  // Each edge consumes the inputs of the cycle it ends; the job's whole
  // output schedule is then fixed by arithmetic on the start cycle.
  initial forever begin
    @(posedge clk);
    ce = cyc;
    if (rst) begin
      m_str.delete(); m_pat.delete();
      m_fresh = 1'b0; m_sent = 1'b0; m_ovf = 1'b0; m_job = 1'b0;
      m_rm = 1'b0; m_rt = 1'b0; m_ri = '0; m_done = -1; m_err = -1;
    end else if (m_job) begin
      if (m_done < 0 && ce >= m_ws) begin
        if (eng.sme_valid) begin
          m_done = ce + 1; m_rm = eng.sme_match; m_ri = eng.sme_match_index; m_rt = 1'b0;
        end else if (ce == m_ws + TMO - 1) begin
          m_done = ce + 1; m_rm = 1'b0; m_ri = '0; m_rt = 1'b1;
        end
      end else if (ce == m_done) begin
        m_job = 1'b0; m_pat.delete(); m_fresh = 1'b1;
      end
    end else if (start) begin
      if (m_pat.size() == 0 || (keep_string ? !m_sent : m_str.size() == 0)) begin
        m_err = ce + 1;
      end else begin
        m_job = 1'b1; m_T = ce; m_done = -1; m_ovf = 1'b0;
        m_Ls = keep_string ? 0 : m_str.size();
        m_P  = m_pat.size();
        m_js = m_str; m_jp = m_pat;
        m_ws = m_T + m_Ls + m_P + 1;
        if (!keep_string) m_sent = 1'b1;
      end
    end else if (wr_en) begin
      if (!wr_sel) begin
        if (m_fresh) begin m_str.delete(); m_str.push_back(wr_data); m_fresh = 1'b0; end
        else if (m_str.size() == SMAX) m_ovf = 1'b1;
        else m_str.push_back(wr_data);
      end else begin
        if (m_pat.size() == PMAX) m_ovf = 1'b1;
        else m_pat.push_back(wr_data);
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- per-cycle compare ----------------
  logic [20:0] exp_v, act_v;
  logic [7:0]  ec;
  logic        eis, eip;
  int          k;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      ec = '0; eis = 1'b0; eip = 1'b0;
      if (m_job) begin
        k = cyc - m_T;
        if (k >= 1 && k <= m_Ls) begin eis = 1'b1; ec = m_js[k-1]; end
        else if (k > m_Ls && k <= m_Ls + m_P) begin eip = 1'b1; ec = m_jp[k-m_Ls-1]; end
      end
      exp_v = {ec, eis, eip, m_job, (m_job && cyc == m_done), (cyc == m_err), m_ovf, m_rm, m_ri, m_rt};
      act_v = {eng.chardata, eng.isstring, eng.ispattern, busy, done, err, wr_ovf,
               res_match, res_index, res_timeout};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL model cyc=%0d got %h want %h (char,is,ip,busy,done,err,ovf,rm,ri,rt)",
                 cyc, act_v, exp_v);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic wr(input logic sel, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(input logic keep);
    start = 1'b1; keep_string = keep;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] s1 [5] = '{8'h61, 8'h62, 8'h20, 8'h63, 8'h61};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    eng.sme_valid = 1'b0; eng.sme_match = 1'b0; eng.sme_match_index = '0;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_outputs", {busy, done, err, wr_ovf, res_match, res_index, res_timeout,
                          eng.isstring, eng.ispattern, eng.chardata}, 0);
    rst = 1'b0;

    // 1: "ab ca" / "ca", engine answers match at index 3 at T+10
    foreach (s1[i]) wr(1'b0, s1[i]);
    wr(1'b1, 8'h63); wr(1'b1, 8'h61);
    go(1'b0);                                   // now in T+1
    for (int i = 0; i < 5; i++) begin
      chk("t1_isstring", eng.isstring, 1); chk("t1_str_char", eng.chardata, s1[i]);
      tick();
    end
    chk("t1_ispat0", eng.ispattern, 1); chk("t1_pat0", eng.chardata, 8'h63); tick();
    chk("t1_ispat1", eng.ispattern, 1); chk("t1_pat1", eng.chardata, 8'h61); tick();
    chk("t1_idle_bus", {eng.isstring, eng.ispattern, busy}, 3'b001);
    tick(); tick();                             // T+10
    eng.sme_valid = 1'b1; eng.sme_match = 1'b1; eng.sme_match_index = 5'd3;
    tick();                                     // T+11
    eng.sme_valid = 1'b0;
    chk("t1_done", done, 1); chk("t1_match", res_match, 1); chk("t1_index", res_index, 3);
    tick();
    chk("t1_after", {done, busy, res_match, res_index}, {2'b00, 1'b1, 5'd3});

    // 2: keep_string, pattern "^a"
    wr(1'b1, 8'h5E); wr(1'b1, 8'h61);
    go(1'b1);
    chk("t2_nostr", eng.isstring, 0); chk("t2_ispat0", eng.ispattern, 1); chk("t2_pat0", eng.chardata, 8'h5E);
    tick();
    chk("t2_ispat1", eng.ispattern, 1); chk("t2_pat1", eng.chardata, 8'h61);
    tick();
    chk("t2_wait", {eng.ispattern, busy}, 2'b01);
    eng.sme_valid = 1'b1; eng.sme_match = 1'b1; eng.sme_match_index = 5'd7;
    tick();
    eng.sme_valid = 1'b0;
    chk("t2_done", {done, res_match, res_index}, {2'b11, 5'd7});
    tick();

    // 3: timeout, WAIT lasts TMO cycles
    wr(1'b1, 8'h78);
    go(1'b1);                                   // T+1, WAIT starts T+2
    for (int i = 0; i < TMO; i++) tick();       // T+17
    chk("t3_not_yet", {done, busy}, 2'b01);
    tick();                                     // T+18
    chk("t3_done", done, 1); chk("t3_timeout", res_timeout, 1);
    chk("t3_res", {res_match, res_index}, 0);
    tick();

    // 4: pattern overflow, only 8 chars sent, wr_ovf cleared by start
    for (int i = 0; i < 9; i++) wr(1'b1, 8'(8'h41 + i));
    chk("t4_ovf_set", wr_ovf, 1);
    go(1'b1);
    chk("t4_ovf_clr", wr_ovf, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_ispat", eng.ispattern, 1); chk("t4_pat", eng.chardata, 8'(8'h41 + i));
      tick();
    end
    chk("t4_end", eng.ispattern, 0);
    eng.sme_valid = 1'b1; eng.sme_match = 1'b0; eng.sme_match_index = 5'd0;
    tick();
    eng.sme_valid = 1'b0;
    chk("t4_done", {done, res_timeout}, 2'b10);
    tick();

    // 5: start with empty pattern
    go(1'b0);
    chk("t5_err", err, 1); chk("t5_quiet", {busy, eng.isstring, eng.ispattern}, 0);
    tick();
    chk("t5_err_pulse", err, 0);

    // 6: reset in the third string cycle
    wr(1'b0, 8'h68); wr(1'b0, 8'h65); wr(1'b0, 8'h6C); wr(1'b0, 8'h6C); wr(1'b0, 8'h6F);
    wr(1'b1, 8'h6C);
    go(1'b0); tick(); tick();                   // T+3
    chk("t6_third", {eng.isstring, eng.chardata}, {1'b1, 8'h6C});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_dropped", {eng.isstring, busy, done}, 0);
    for (int i = 0; i < 4; i++) tick();
    wr(1'b1, 8'h7A);
    go(1'b1);
    chk("t6_err_nostr", err, 1);
    tick();

    // random traffic, checked only by the model
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 699) == 0);
      wr_en       = 1'($urandom_range(0, 1));
      wr_sel      = ($urandom_range(0, 2) == 0);
      wr_data     = 8'($urandom);
      start       = ($urandom_range(0, 14) == 0);
      keep_string = 1'($urandom_range(0, 1));
      eng.sme_valid       = ($urandom_range(0, 5) == 0);
      eng.sme_match       = 1'($urandom_range(0, 1));
      eng.sme_match_index = 5'($urandom);
      tick();
    end
    rst = 1'b0; wr_en = 1'b0; start = 1'b0; eng.sme_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
